// File: rtl/tl_uart_pkg.sv
// Shared definitions for the UART <-> TileLink bridge pair.
// Packet layout (16 bytes, "<BBBBLQ"): byte offsets of each field, bit
// positions inside the opcode byte, and the framer state encoding.
package tl_uart_pkg;

   localparam int PACKET_BYTES = 16;
   localparam int PACKET_BITS  = 8 * PACKET_BYTES;

   localparam int OFF_CHAN  = 0;
   localparam int OFF_OPC   = 1;
   localparam int OFF_SIZE  = 2;
   localparam int OFF_UNION = 3;
   localparam int OFF_ADDR  = 4;   // bytes 4..7
   localparam int OFF_DATA  = 8;   // bytes 8..15

   localparam int OPC_LSB     = 0;
   localparam int OPC_MSB     = 2;
   localparam int PARAM_LSB   = 4;
   localparam int PARAM_MSB   = 6;
   localparam int CORRUPT_BIT = 7;

   typedef enum logic [1:0] {
      ST_COLLECT  = 2'd0,
      ST_PRESENT  = 2'd1,
      ST_DOWNTIME = 2'd2
   } framer_state_e;

   // Extract byte k of a packet buffer (byte 0 in the low bits).
   function automatic logic [7:0] pkt_byte(input logic [PACKET_BITS-1:0] pkt, input int k);
      return pkt[8*k +: 8];
   endfunction

endpackage

// File: rtl/uart_to_tilelink_framer_if.sv
// Byte-stream input and TileLink frame output of the framer.
// master : framer side (accepts bytes, drives frames)
// slave  : environment side (UART client + GenericSerializer)
interface uart_to_tilelink_framer_if;
   import tl_uart_pkg::*;

   logic        rx_byte_valid;
   logic        rx_byte_ready;
   logic [7:0]  rx_byte;

   logic        tl_in_valid;
   logic        tl_in_ready;
   logic [2:0]  tl_in_bits_chanId;
   logic [2:0]  tl_in_bits_opcode;
   logic [2:0]  tl_in_bits_param;
   logic        tl_in_bits_corrupt;
   logic [7:0]  tl_in_bits_size;
   logic [8:0]  tl_in_bits_union;
   logic [7:0]  tl_in_bits_source;
   logic [63:0] tl_in_bits_address;
   logic [63:0] tl_in_bits_data;

   modport master (
      input  rx_byte_valid, rx_byte, tl_in_ready,
      output rx_byte_ready, tl_in_valid,
      output tl_in_bits_chanId, tl_in_bits_opcode, tl_in_bits_param,
      output tl_in_bits_corrupt, tl_in_bits_size, tl_in_bits_union,
      output tl_in_bits_source, tl_in_bits_address, tl_in_bits_data
   );

   modport slave (
      output rx_byte_valid, rx_byte, tl_in_ready,
      input  rx_byte_ready, tl_in_valid,
      input  tl_in_bits_chanId, tl_in_bits_opcode, tl_in_bits_param,
      input  tl_in_bits_corrupt, tl_in_bits_size, tl_in_bits_union,
      input  tl_in_bits_source, tl_in_bits_address, tl_in_bits_data
   );

endinterface

// File: rtl/tl_packet_unpack.sv
// Combinational decode of a 16-byte command packet into TileLink frame fields.
// Ports: i_buf (packet, byte 0 in bits [7:0]) -> o_* frame fields.
module tl_packet_unpack
   import tl_uart_pkg::*;
#(
   parameter logic [7:0] SOURCE_ID = 8'd0
) (
   input  logic [PACKET_BITS-1:0] i_buf,
   output logic [2:0]             o_chan_id,
   output logic [2:0]             o_opcode,
   output logic [2:0]             o_param,
   output logic                   o_corrupt,
   output logic [7:0]             o_size,
   output logic [8:0]             o_union,
   output logic [7:0]             o_source,
   output logic [63:0]            o_address,
   output logic [63:0]            o_data
);

   logic [7:0] w_chan_byte;
   logic [7:0] w_opc_byte;
   logic [4:0] w_unused_chan_hi;

   assign w_chan_byte      = pkt_byte(i_buf, OFF_CHAN);
   assign w_opc_byte       = pkt_byte(i_buf, OFF_OPC);
   // Upper bits of the channel byte carry nothing.
   assign w_unused_chan_hi = w_chan_byte[7:3];

   assign o_chan_id = w_chan_byte[2:0];
   assign o_opcode  = w_opc_byte[OPC_MSB:OPC_LSB];
   assign o_param   = w_opc_byte[PARAM_MSB:PARAM_LSB];
   assign o_corrupt = w_opc_byte[CORRUPT_BIT];
   assign o_size    = pkt_byte(i_buf, OFF_SIZE);
   assign o_union   = {1'b0, pkt_byte(i_buf, OFF_UNION)};
   assign o_source  = SOURCE_ID;
   // Byte order in the buffer already matches little-endian field order.
   assign o_address = {32'h0, i_buf[8*OFF_ADDR +: 32]};
   assign o_data    = i_buf[8*OFF_DATA +: 64];

endmodule

// File: rtl/uart_to_tilelink_framer.sv
// Assembles 16-byte host command packets from a UART byte stream and presents
// them as TileLink frames, paced by edges of the sampled serializer clock.
// Ports: clk, reset (sync, active high), tl_clk (sampled as data),
//        bus (master modport: byte stream in, frame out),
//        timeout_err (drop pulse), frame_count (frames delivered).
//
// state       | meaning
// ST_COLLECT  | accepting bytes into the packet buffer; inter-byte timer runs
// ST_PRESENT  | frame valid, waiting for serializer ready
// ST_DOWNTIME | valid low, waiting for a tl_clk rising edge before next packet
module uart_to_tilelink_framer
   import tl_uart_pkg::*;
#(
   parameter int         TIMEOUT_CYCLES = 1000000,
   parameter int         TIMEOUT_W      = 20,
   parameter logic [7:0] SOURCE_ID      = 8'd0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       tl_clk,
   uart_to_tilelink_framer_if.master  bus,
   output logic                       timeout_err,
   output logic [15:0]                frame_count
);

   localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   framer_state_e          r_state;
   framer_state_e          w_state_nxt;
   logic                   r_tl_clk_q;
   logic [3:0]             r_idx;
   logic [TIMEOUT_W-1:0]   r_tmo_cnt;
   logic [PACKET_BITS-1:0] r_buf;
   logic                   r_tmo_err;
   logic [15:0]            r_frame_cnt;

   logic w_tl_clk_pos;
   logic w_accept;
   logic w_last_byte;
   logic w_tmo_hit;
   logic w_handshake;

   assign w_tl_clk_pos = tl_clk & ~r_tl_clk_q;
   assign w_accept     = (r_state == ST_COLLECT) && bus.rx_byte_valid;
   assign w_last_byte  = w_accept && (r_idx == 4'(PACKET_BYTES - 1));
   // An accepted byte always beats an expiring timer.
   assign w_tmo_hit    = (r_state == ST_COLLECT) && (r_idx != 4'd0) && !w_accept
                         && (r_tmo_cnt == TMO_LAST);
   assign w_handshake  = (r_state == ST_PRESENT) && bus.tl_in_ready;

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_COLLECT;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_COLLECT:  if (w_last_byte)  w_state_nxt = ST_PRESENT;
         ST_PRESENT:  if (w_handshake)  w_state_nxt = ST_DOWNTIME;
         ST_DOWNTIME: if (w_tl_clk_pos) w_state_nxt = ST_COLLECT;
         default:                       w_state_nxt = ST_COLLECT;
      endcase
   end

   always_comb begin
      bus.rx_byte_ready = (r_state == ST_COLLECT);
      bus.tl_in_valid   = (r_state == ST_PRESENT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tl_clk_q  <= 1'b0;
         r_idx       <= 4'd0;
         r_tmo_cnt   <= '0;
         r_buf       <= '0;
         r_tmo_err   <= 1'b0;
         r_frame_cnt <= 16'd0;
      end else begin
         r_tl_clk_q <= tl_clk;
         r_tmo_err  <= w_tmo_hit;

         if (w_accept) begin
            r_buf[{r_idx, 3'b000} +: 8] <= bus.rx_byte;
            r_idx                       <= w_last_byte ? 4'd0 : r_idx + 4'd1;
         end else if (w_tmo_hit) begin
            r_idx <= 4'd0;
         end

         if (w_accept || w_tmo_hit)
            r_tmo_cnt <= '0;
         else if ((r_state == ST_COLLECT) && (r_idx != 4'd0))
            r_tmo_cnt <= r_tmo_cnt + 1'b1;

         if (w_handshake)
            r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

   assign timeout_err = r_tmo_err;
   assign frame_count = r_frame_cnt;

   tl_packet_unpack #(
      .SOURCE_ID (SOURCE_ID)
   ) u_unpack (
      .i_buf     (r_buf),
      .o_chan_id (bus.tl_in_bits_chanId),
      .o_opcode  (bus.tl_in_bits_opcode),
      .o_param   (bus.tl_in_bits_param),
      .o_corrupt (bus.tl_in_bits_corrupt),
      .o_size    (bus.tl_in_bits_size),
      .o_union   (bus.tl_in_bits_union),
      .o_source  (bus.tl_in_bits_source),
      .o_address (bus.tl_in_bits_address),
      .o_data    (bus.tl_in_bits_data)
   );

endmodule
